// File: rtl/inv_bridge_deadtime.sv
// CH-channel complementary inverter driver with programmable break-before-make
// dead time and per-channel polarity. Outputs are decoded from the state register.
module inv_bridge_deadtime #(
  parameter int unsigned CH         = 4,
  parameter int unsigned DT_W       = 4,
  parameter int unsigned DT_DEFAULT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [CH-1:0]   in_req,
  input  logic [CH-1:0]   inv_pol,
  input  logic [DT_W-1:0] dt_cfg,
  input  logic            dt_load,
  output logic [CH-1:0]   hs_out,
  output logic [CH-1:0]   ls_out,
  output logic [CH-1:0]   busy
);

  typedef enum logic [1:0] {OFF, HS_ON, LS_ON, DEAD} state_t;

  state_t          state_q [CH];
  state_t          state_d [CH];
  logic [DT_W-1:0] cnt_q   [CH];
  logic [DT_W-1:0] cnt_d   [CH];
  logic [CH-1:0]   r_q;
  logic [DT_W-1:0] dt_reg;
  logic [DT_W-1:0] d_m1;

  // Dead-time counter preload: a programmed value of 0 still yields one dead cycle.
  assign d_m1 = (dt_reg == '0) ? '0 : dt_reg - DT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      dt_reg <= DT_W'(DT_DEFAULT);
    end else begin
      r_q <= in_req ^ inv_pol;
      if (dt_load) dt_reg <= dt_cfg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    hs_out = '0;
    ls_out = '0;
    busy   = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!ena) begin
        state_d[i] = OFF;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          OFF: begin
            state_d[i] = DEAD;
            cnt_d[i]   = d_m1;
          end
          HS_ON: if (!r_q[i]) begin
            state_d[i] = DEAD;
            cnt_d[i]   = d_m1;
          end
          LS_ON: if (r_q[i]) begin
            state_d[i] = DEAD;
            cnt_d[i]   = d_m1;
          end
          DEAD: begin
            // Target side is whatever the request is when the count expires.
            if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - DT_W'(1);
            else                state_d[i] = r_q[i] ? HS_ON : LS_ON;
          end
          default: begin
            state_d[i] = OFF;
            cnt_d[i]   = '0;
          end
        endcase
      end
      hs_out[i] = (state_q[i] == HS_ON);
      ls_out[i] = (state_q[i] == LS_ON);
      busy[i]   = (state_q[i] == DEAD);
    end
  end

endmodule

// File: tb/tb_inv_bridge_deadtime.sv
// Scoreboard bench for inv_bridge_deadtime: stimulus queues hand-computed
// {hs,ls,busy} expectations tagged by clock edge; a monitor pops and compares.
module tb_inv_bridge_deadtime;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [3:0] in_req;
  logic [3:0] inv_pol;
  logic [3:0] dt_cfg;
  logic       dt_load;
  logic [3:0] hs_out;
  logic [3:0] ls_out;
  logic [3:0] busy;

  inv_bridge_deadtime #(.CH(4), .DT_W(4), .DT_DEFAULT(3)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_req(in_req), .inv_pol(inv_pol),
    .dt_cfg(dt_cfg), .dt_load(dt_load),
    .hs_out(hs_out), .ls_out(ls_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] h;
    logic [3:0] l;
    logic [3:0] b;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got hs/ls/busy=%h expected %h", nm, cyc, act, exp);
    end
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_rel(int rel, logic [3:0] h, logic [3:0] l, logic [3:0] b, string nm);
    exp_t e;
    e.cyc = cyc + rel;
    e.h   = h;
    e.l   = l;
    e.b   = b;
    e.nm  = nm;
    q.push_back(e);
  endtask

  // Monitor: shoot-through invariant every cycle, plus scoreboard pops.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if ((hs_out & ls_out) !== 4'b0) begin
        errors++;
        $display("FAIL shoot_through at edge %0d: hs=%h ls=%h expected no overlap", cyc, hs_out, ls_out);
      end
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for edge %0d missed (now %0d)", e.nm, e.cyc, cyc);
        end else begin
          chk(e.nm, {hs_out, ls_out, busy}, {e.h, e.l, e.b});
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ena = 1'b0; in_req = 4'hF; inv_pol = 4'h0; dt_cfg = 4'h0; dt_load = 1'b0;
    #1 rst = 1'b1;
    #1 chk("async_reset_init", {hs_out, ls_out, busy}, 12'h000);
    step(2);

    // Release, enable: full default dead time (3) then all high side.
    rst = 1'b0; ena = 1'b1;
    exp_rel(0, 4'h0, 4'h0, 4'h0, "rel_off");
    for (int i = 1; i <= 3; i++) exp_rel(i, 4'h0, 4'h0, 4'hF, "startup_dead");
    exp_rel(4, 4'hF, 4'h0, 4'h0, "startup_hs");
    step(6);

    // dt=5, ch0 1->0.
    dt_cfg = 4'd5; dt_load = 1'b1;
    step(1);
    dt_load = 1'b0; in_req = 4'hE;
    exp_rel(1, 4'hF, 4'h0, 4'h0, "dt5_hold");
    for (int i = 2; i <= 6; i++) exp_rel(i, 4'hE, 4'h0, 4'h1, "dt5_dead");
    exp_rel(7, 4'hE, 4'h1, 4'h0, "dt5_ls0");
    step(9);

    // dt=0 behaves as one dead cycle, ch1 1->0.
    dt_cfg = 4'd0; dt_load = 1'b1;
    step(1);
    dt_load = 1'b0; in_req = 4'hC;
    exp_rel(1, 4'hE, 4'h1, 4'h0, "dt0_hold");
    exp_rel(2, 4'hC, 4'h1, 4'h2, "dt0_dead");
    exp_rel(3, 4'hC, 4'h3, 4'h0, "dt0_ls1");
    step(5);

    // dt=4, ch2 1->0 then back mid-dead: no restart, returns to high side.
    dt_cfg = 4'd4; dt_load = 1'b1;
    step(1);
    dt_load = 1'b0; in_req = 4'h8;
    exp_rel(1, 4'hC, 4'h3, 4'h0, "glitch_hold");
    for (int i = 2; i <= 5; i++) exp_rel(i, 4'h8, 4'h3, 4'h4, "glitch_dead");
    exp_rel(6, 4'hC, 4'h3, 4'h0, "glitch_hs2");
    exp_rel(7, 4'hC, 4'h3, 4'h0, "glitch_hs2_hold");
    step(2);
    in_req = 4'hC;
    step(7);

    // ch3 enters dead, then ena=0 mid-dead/mid-HS.
    in_req = 4'h4;
    exp_rel(1, 4'hC, 4'h3, 4'h0, "ena_hold");
    exp_rel(2, 4'h4, 4'h3, 4'h8, "ena_dead3");
    exp_rel(3, 4'h4, 4'h3, 4'h8, "ena_dead3b");
    exp_rel(4, 4'h0, 4'h0, 4'h0, "ena_off");
    step(3);
    ena = 1'b0;
    step(2);
    ena = 1'b1;
    exp_rel(0, 4'h0, 4'h0, 4'h0, "reena_off");
    for (int i = 1; i <= 4; i++) exp_rel(i, 4'h0, 4'h0, 4'hF, "reena_dead");
    exp_rel(5, 4'h4, 4'hB, 4'h0, "reena_drive");
    step(7);

    // Async reset mid-drive; dt reverts to default 3.
    #2 rst = 1'b1;
    #1 chk("async_reset_mid", {hs_out, ls_out, busy}, 12'h000);
    exp_rel(0, 4'h0, 4'h0, 4'h0, "rst_off");
    step(1);
    rst = 1'b0;
    exp_rel(0, 4'h0, 4'h0, 4'h0, "rst_rel_off");
    for (int i = 1; i <= 3; i++) exp_rel(i, 4'h0, 4'h0, 4'hF, "rst_rel_dead");
    exp_rel(4, 4'h4, 4'hB, 4'h0, "rst_rel_drive");
    step(6);

    // Polarity: ch2 inverted; dt_load on the dead-entry edge keeps old dt=3.
    in_req = 4'hF; inv_pol = 4'h4;
    exp_rel(1, 4'h4, 4'hB, 4'h0, "pol_hold");
    for (int i = 2; i <= 4; i++) exp_rel(i, 4'h0, 4'h0, 4'hF, "pol_dead");
    exp_rel(5, 4'hB, 4'h4, 4'h0, "pol_drive");
    exp_rel(6, 4'hB, 4'h4, 4'h0, "pol_drive_hold");
    step(1);
    dt_cfg = 4'd7; dt_load = 1'b1;
    step(1);
    dt_load = 1'b0;
    step(8);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
